// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter sharing one 16x4 FIFO among NREQ nibble producers, with credit tracking.
// Optional FIFO_ARB_PRIO_EN: requester 0 gets absolute priority; 1..NREQ-1 round-robin among themselves.

module fifo_wr_arbiter_lane (
    input  logic       req,
    input  logic       ack_q,
    input  logic       gnt,
    input  logic [3:0] data,
    output logic       elig,
    output logic [3:0] dsel
);
    // The lane just acked is masked so a still-high req cannot win twice in a row.
    assign elig = req & ~ack_q;
    assign dsel = data & {4{gnt}};
endmodule

module fifo_wr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [4*NREQ-1:0] data,
    output logic [NREQ-1:0]   ack,
    output logic              fifo_wr,
    output logic [3:0]        fifo_w_data,
    input  logic              fifo_rd,
    input  logic              fifo_empty,
    output logic [4:0]        credit
);
    localparam int IW = $clog2(NREQ);
    localparam logic [4:0] CREDIT_MAX = 5'd16;

    logic [NREQ-1:0][3:0] data_v;
    logic [NREQ-1:0][3:0] dsel;
    logic [NREQ-1:0]      elig;
    logic [NREQ-1:0]      gnt;

    logic [NREQ-1:0] ack_q, ack_d;
    logic            fifo_wr_q, fifo_wr_d;
    logic [3:0]      fifo_w_data_q, fifo_w_data_d;
    logic [4:0]      credit_q, credit_d;
    logic [IW-1:0]   last_q, last_d;

    logic          issue;
    logic          pop;
    logic          found;
    logic [IW-1:0] win;
    logic [IW:0]   sum;
    logic [3:0]    wdata;

    assign data_v = data;

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        fifo_wr_arbiter_lane u_lane (
            .req   (req[i]),
            .ack_q (ack_q[i]),
            .gnt   (gnt[i]),
            .data  (data_v[i]),
            .elig  (elig[i]),
            .dsel  (dsel[i])
        );
    end

    assign issue = (|elig) && (credit_q != 5'd0);
    assign pop   = fifo_rd & ~fifo_empty;

    // Winner search starts one past the last grant and wraps; first eligible index wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
`ifdef FIFO_ARB_PRIO_EN
        if (elig[0]) begin
            found = 1'b1;
        end
        // last_q stays within 1..NREQ-1 here, so the ring excludes requester 0.
        for (int k = 1; k < NREQ; k++) begin
            sum = {1'b0, last_q} + (IW+1)'(k);
            if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ - 1);
            if (!found && elig[sum[IW-1:0]]) begin
                found = 1'b1;
                win   = sum[IW-1:0];
            end
        end
`else
        for (int k = 1; k <= NREQ; k++) begin
            sum = {1'b0, last_q} + (IW+1)'(k);
            if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
            if (!found && elig[sum[IW-1:0]]) begin
                found = 1'b1;
                win   = sum[IW-1:0];
            end
        end
`endif
    end

    always_comb begin
        gnt = '0;
        if (issue) gnt[win] = 1'b1;
    end

    always_comb begin
        wdata = '0;
        for (int i = 0; i < NREQ; i++) wdata = wdata | dsel[i];
    end

    always_comb begin
        ack_d         = gnt;
        fifo_wr_d     = issue;
        fifo_w_data_d = issue ? wdata : fifo_w_data_q;
        last_d        = last_q;
`ifdef FIFO_ARB_PRIO_EN
        if (issue && (win != '0)) last_d = win;
`else
        if (issue) last_d = win;
`endif
        credit_d = credit_q;
        if (issue && !pop) begin
            credit_d = credit_q - 5'd1;
        end else if (pop && !issue && (credit_q != CREDIT_MAX)) begin
            // Saturate: a pop at full credit cannot happen with a shared reset.
            credit_d = credit_q + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack_q         <= '0;
            fifo_wr_q     <= 1'b0;
            fifo_w_data_q <= '0;
            credit_q      <= CREDIT_MAX;
            last_q        <= IW'(NREQ - 1);
        end else begin
            ack_q         <= ack_d;
            fifo_wr_q     <= fifo_wr_d;
            fifo_w_data_q <= fifo_w_data_d;
            credit_q      <= credit_d;
            last_q        <= last_d;
        end
    end

    assign ack         = ack_q;
    assign fifo_wr     = fifo_wr_q;
    assign fifo_w_data = fifo_w_data_q;
    assign credit      = credit_q;

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares one 16-entry x 4-bit FIFO among `NREQ` nibble producers. It sits between the producers and the FIFO's `wr`/`w_data` port, grants at most one nibble per cycle, and tracks free FIFO slots with its own credit counter, so no write is ever issued into a full FIFO despite the registered write path. The FIFO's consumer pops are observed, never driven.

## Interface
- `NREQ`, 4: number of requesters; legal range 2..8.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset; all state is cleared while low. Must be the same reset as the FIFO's.
- `req`  in  NREQ  per-requester write request, level; requester i holds it until `ack[i]`.
- `data`  in  4*NREQ  flattened nibbles; requester i at bits [4i+3:4i]; stable while `req[i]` is high.
- `ack`  out  NREQ  one-cycle pulse: requester i's nibble is being written this cycle.
- `fifo_wr`  out  1  registered write strobe to the FIFO.
- `fifo_w_data`  out  4  registered write data to the FIFO.
- `fifo_rd`  in  1  consumer read strobe, as presented to the FIFO.
- `fifo_empty`  in  1  FIFO empty flag.
- `credit`  out  5  free FIFO slots as seen by the arbiter, 0..16.

## Operation
- Issue pipeline: one decision stage plus one output register. There is no other FSM; state is the credit counter, the round-robin pointer `last`, and the output register.
- Eligibility: `elig[i] = req[i] & ~ack[i]`. Masking the acked requester prevents a double grant while its `req` is still high in the ack cycle.
- Issue condition: `|elig & (credit != 0)`.
- Winner selection (round-robin): search order is `last+1, last+2, …` modulo `NREQ`; the first eligible index wins.
- On issue with winner w, at the next edge:
  - `fifo_wr <= 1`, `fifo_w_data <= data[4w+3:4w]`
  - `ack <= one-hot(w)`
  - `last <= w`
- With no issue, `fifo_wr <= 0` and `ack <= 0`; `fifo_w_data` holds its previous value.
- Pop detect: `pop = fifo_rd & ~fifo_empty`.
- Credit update: `credit_next = credit - issue + pop`. Simultaneous issue and pop leaves `credit` unchanged.
- `credit` never exceeds 16 and never underflows. A pop with `credit == 16` is impossible when the FIFO and arbiter share reset.
- Credits are charged at issue, one cycle before the FIFO write, so `credit` is always ≤ the FIFO's true free count.
- `req` dropped before `ack` is allowed (withdrawal). A nibble already issued is still written.

## Timing
- Reset values: `ack = 0`, `fifo_wr = 0`, `fifo_w_data = 0`, `credit = 16`, `last = NREQ-1` (requester 0 wins first).
- Latency: `req[i]` sampled high at edge N → `fifo_wr` and `ack[i]` high during cycle N+1 → FIFO writes at the end of N+1.
- Throughput:
  - one nibble per cycle total across different requesters
  - at most one nibble per two cycles for a single requester, because of the ack mask
- At `credit == 0`: no issue, `ack` stays 0, and requests wait. A pop in that cycle enables an issue in the following cycle.
- Reset asserted mid-operation: a pending `fifo_wr` is cancelled asynchronously and credits return to 16. The FIFO is reset by the same signal, so the two stay consistent.

## Configuration
- `FIFO_ARB_PRIO_EN`
  - Defined: requester 0 has fixed absolute priority and wins whenever `elig[0]` is set; requesters 1..NREQ-1 round-robin among themselves using `last`, which updates only on grants to 1..NREQ-1.
  - Undefined: plain round-robin over all `NREQ` requesters, as described above.

## Test plan
- Reset, then `req[2]=1` with data nibble `0xA` → `fifo_wr=1`, `fifo_w_data=0xA`, `ack=4'b0100` exactly one cycle later; `credit` goes 16→15.
- `req=4'b1111` held high, nibbles 0..3, no pops → grants in order 0,1,2,3,0,… with one grant per cycle; after 16 issues `credit=0` and `fifo_wr` stays low.
- At `credit=0` with requests pending, pulse `fifo_rd` once with `fifo_empty=0` → `credit` goes 0→1, exactly one issue the next cycle, then `credit` returns to 0.
- At `credit=5`, issue and pop in the same cycle → `credit` stays 5; with `fifo_rd=1` and `fifo_empty=1`, `credit` is unchanged by the read.
- Assert `reset` low while `fifo_wr=1` → `fifo_wr`, `ack` clear immediately; `credit=16`; the first grant after release goes to requester 0.
- With `FIFO_ARB_PRIO_EN` defined and `req=4'b1011` held → requester 0 wins every cycle it is eligible; requesters 1 and 3 alternate in the masked cycles.
